// File: rtl/mem_stage_data_memory.sv
// MEM-stage data memory: little-endian byte/half/word loads and stores on a
// small register-file array, plus a handshaked dump port for reading it out.
module mem_stage_data_memory #(
  parameter int NB           = 32,
  parameter int NB_SIZE_TYPE = 3,
  parameter int NB_ADDR      = 5
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_step,
  input  logic [NB-1:0]           i_alu_result,
  input  logic [NB-1:0]           i_data_b,
  input  logic                    i_mem_read,
  input  logic                    i_mem_write,
  input  logic [NB_SIZE_TYPE-1:0] i_word_size,
  input  logic                    i_dump_start,
  input  logic                    i_dump_ready,
  output logic [NB-1:0]           o_read_data,
  output logic                    o_misaligned,
  output logic                    o_dump_valid,
  output logic [NB_ADDR-1:0]      o_dump_addr,
  output logic [NB-1:0]           o_dump_data,
  output logic                    o_dump_busy,
  output logic                    o_dump_done
);

  localparam int NWORDS = 1 << NB_ADDR;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [NB-1:0]      mem_q [NWORDS];
  logic [1:0]         state_q, state_d;
  logic [NB_ADDR-1:0] dumpIdx_q, dumpIdx_d;

  logic [NB_ADDR-1:0] wordIdx;
  logic [1:0]         byteOff;
  logic [1:0]         sizeCode;
  logic               isByte, isHalf, isWord;
  logic               unsignedLoad;
  logic               misaligned;
  logic               storeEn;
  logic [4:0]         laneShift;
  logic [NB-1:0]      readWord, readShifted, loadData;
  logic [NB-1:0]      storeMask, storeData;
  logic               unusedAddrBits;

  // Upper address bits are deliberately ignored so addresses wrap.
  assign unusedAddrBits = ^i_alu_result[NB-1:NB_ADDR+2];

  assign wordIdx      = i_alu_result[NB_ADDR+1:2];
  assign byteOff      = i_alu_result[1:0];
  assign sizeCode     = i_word_size[1:0];
  assign unsignedLoad = i_word_size[2];
  assign isByte       = (sizeCode == 2'b00);
  assign isHalf       = (sizeCode == 2'b01);
  assign isWord       = sizeCode[1];
  assign laneShift    = {byteOff, 3'b000};

  assign misaligned   = (isHalf & byteOff[0]) | (isWord & (byteOff != 2'b00));
  assign o_misaligned = (i_mem_read | i_mem_write) & misaligned;
  assign storeEn      = i_step & i_mem_write & ~misaligned & ~o_dump_busy;

  // Load path reads the array as it stands before the edge, so a same-word
  // store in the same cycle is not visible until the next cycle.
  always_comb begin
    readWord    = mem_q[wordIdx];
    readShifted = readWord >> laneShift;
    loadData    = '0;
    if (i_mem_read && !misaligned) begin
      if (isByte) begin
        loadData = {{(NB-8){~unsignedLoad & readShifted[7]}}, readShifted[7:0]};
      end else if (isHalf) begin
        loadData = {{(NB-16){~unsignedLoad & readShifted[15]}}, readShifted[15:0]};
      end else begin
        loadData = readWord;
      end
    end
  end

  assign o_read_data = loadData;

  // Store data is replicated across all lanes; the mask picks the live one.
  always_comb begin
    storeMask = '0;
    storeData = '0;
    if (isByte) begin
      storeMask = NB'(8'hFF) << laneShift;
      storeData = {(NB/8){i_data_b[7:0]}};
    end else if (isHalf) begin
      storeMask = NB'(16'hFFFF) << laneShift;
      storeData = {(NB/16){i_data_b[15:0]}};
    end else begin
      storeMask = '1;
      storeData = i_data_b;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NWORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (storeEn) begin
      mem_q[wordIdx] <= (mem_q[wordIdx] & ~storeMask) | (storeData & storeMask);
    end
  end

  always_comb begin
    state_d   = state_q;
    dumpIdx_d = dumpIdx_q;
    case (state_q)
      IDLE: begin
        if (i_dump_start) begin
          dumpIdx_d = '0;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (i_dump_ready) begin
          if (&dumpIdx_q) begin
            state_d = DONE;
          end else begin
            dumpIdx_d = dumpIdx_q + NB_ADDR'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      dumpIdx_q <= '0;
    end else begin
      state_q   <= state_d;
      dumpIdx_q <= dumpIdx_d;
    end
  end

  assign o_dump_valid = (state_q == SEND);
  assign o_dump_busy  = (state_q != IDLE);
  assign o_dump_done  = (state_q == DONE);
  assign o_dump_addr  = o_dump_valid ? dumpIdx_q : '0;
  assign o_dump_data  = o_dump_valid ? mem_q[dumpIdx_q] : '0;

endmodule

// File: tb/tb_mem_stage_data_memory.sv
// Directed bench for mem_stage_data_memory: load/store lanes, alignment,
// stepping, aliasing, dump handshake and reset in the middle of a dump.
module tb_mem_stage_data_memory;

  logic        i_clk;
  logic        i_reset;
  logic        i_step;
  logic [31:0] i_alu_result;
  logic [31:0] i_data_b;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [2:0]  i_word_size;
  logic        i_dump_start;
  logic        i_dump_ready;
  logic [31:0] o_read_data;
  logic        o_misaligned;
  logic        o_dump_valid;
  logic [4:0]  o_dump_addr;
  logic [31:0] o_dump_data;
  logic        o_dump_busy;
  logic        o_dump_done;

  int testCount = 0;
  int failCount = 0;

  localparam logic [2:0] SZ_BYTE  = 3'b000;
  localparam logic [2:0] SZ_HALF  = 3'b001;
  localparam logic [2:0] SZ_WORD  = 3'b010;
  localparam logic [2:0] SZ_BYTEU = 3'b100;
  localparam logic [2:0] SZ_HALFU = 3'b101;
  localparam logic [2:0] SZ_WORD3 = 3'b011;

  mem_stage_data_memory #(.NB(32), .NB_SIZE_TYPE(3), .NB_ADDR(5)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_step       (i_step),
    .i_alu_result (i_alu_result),
    .i_data_b     (i_data_b),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_word_size  (i_word_size),
    .i_dump_start (i_dump_start),
    .i_dump_ready (i_dump_ready),
    .o_read_data  (o_read_data),
    .o_misaligned (o_misaligned),
    .o_dump_valid (o_dump_valid),
    .o_dump_addr  (o_dump_addr),
    .o_dump_data  (o_dump_data),
    .o_dump_busy  (o_dump_busy),
    .o_dump_done  (o_dump_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one MEM-stage access and lets the combinational paths settle.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic rd, input logic wr,
                               input logic [2:0] size, input logic step);
    i_alu_result = addr;
    i_data_b     = data;
    i_mem_read   = rd;
    i_mem_write  = wr;
    i_word_size  = size;
    i_step       = step;
    #1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset      = 1'b1;
    i_dump_start = 1'b0;
    i_dump_ready = 1'b0;
    applyStimulus(32'h08, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b0);
    tick();
    checkOutput("reset_read",  o_read_data,         32'h0);
    checkOutput("reset_valid", {31'd0, o_dump_valid}, 32'd0);
    checkOutput("reset_busy",  {31'd0, o_dump_busy},  32'd0);
    checkOutput("reset_done",  {31'd0, o_dump_done},  32'd0);
    i_reset = 1'b0;
    tick();

    // Word store then load
    applyStimulus(32'h08, 32'hDEADBEEF, 1'b0, 1'b1, SZ_WORD, 1'b1);
    checkOutput("word_st_mis", {31'd0, o_misaligned}, 32'd0);
    tick();
    applyStimulus(32'h08, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1);
    checkOutput("word_ld", o_read_data, 32'hDEADBEEF);
    checkOutput("word_ld_mis", {31'd0, o_misaligned}, 32'd0);

    // Store with step low is ignored; 0x88 aliases word 2
    applyStimulus(32'h08, 32'h12345678, 1'b0, 1'b1, SZ_WORD, 1'b0);
    tick();
    applyStimulus(32'h08, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1);
    checkOutput("step0_hold", o_read_data, 32'hDEADBEEF);
    applyStimulus(32'h88, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1);
    checkOutput("alias_ld", o_read_data, 32'hDEADBEEF);
    applyStimulus(32'h88, 32'h0, 1'b0, 1'b1, SZ_WORD, 1'b1);
    tick();
    applyStimulus(32'h08, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1);
    checkOutput("alias_st", o_read_data, 32'h0);

    // Byte lane 3 with junk in the upper store bits
    applyStimulus(32'h0B, 32'hAAAAAA80, 1'b0, 1'b1, SZ_BYTE, 1'b1);
    tick();
    applyStimulus(32'h0B, 32'h0, 1'b1, 1'b0, SZ_BYTE, 1'b1);
    checkOutput("byte_ld_s", o_read_data, 32'hFFFFFF80);
    applyStimulus(32'h0B, 32'h0, 1'b1, 1'b0, SZ_BYTEU, 1'b1);
    checkOutput("byte_ld_u", o_read_data, 32'h00000080);
    applyStimulus(32'h08, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1);
    checkOutput("byte_word", o_read_data, 32'h80000000);

    // Misaligned half store is dropped
    applyStimulus(32'h09, 32'h00001234, 1'b0, 1'b1, SZ_HALF, 1'b1);
    checkOutput("half_st_mis", {31'd0, o_misaligned}, 32'd1);
    tick();
    applyStimulus(32'h08, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1);
    checkOutput("half_mis_word", o_read_data, 32'h80000000);
    applyStimulus(32'h09, 32'h0, 1'b1, 1'b0, SZ_HALF, 1'b1);
    checkOutput("half_ld_mis", o_read_data, 32'h0);
    checkOutput("half_ld_misf", {31'd0, o_misaligned}, 32'd1);
    applyStimulus(32'h09, 32'h0, 1'b0, 1'b0, SZ_HALF, 1'b1);
    checkOutput("mis_idle", {31'd0, o_misaligned}, 32'd0);

    // Aligned half in upper lane
    applyStimulus(32'h0A, 32'h5555F00D, 1'b0, 1'b1, SZ_HALF, 1'b1);
    tick();
    applyStimulus(32'h0A, 32'h0, 1'b1, 1'b0, SZ_HALF, 1'b1);
    checkOutput("half_ld_s", o_read_data, 32'hFFFFF00D);
    applyStimulus(32'h0A, 32'h0, 1'b1, 1'b0, SZ_HALFU, 1'b1);
    checkOutput("half_ld_u", o_read_data, 32'h0000F00D);
    applyStimulus(32'h08, 32'h0, 1'b1, 1'b0, SZ_WORD3, 1'b1);
    checkOutput("size11_word", o_read_data, 32'hF00D0000);
    applyStimulus(32'h0A, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1);
    checkOutput("word_ld_mis0", o_read_data, 32'h0);
    checkOutput("word_mis_flag", {31'd0, o_misaligned}, 32'd1);

    // Same-word read and write: load sees pre-edge contents
    applyStimulus(32'h10, 32'h11112222, 1'b1, 1'b1, SZ_WORD, 1'b1);
    checkOutput("rw_before", o_read_data, 32'h0);
    tick();
    checkOutput("rw_after", o_read_data, 32'h11112222);

    // Seed words 1 and 31 for the dump
    applyStimulus(32'h04, 32'h00000101, 1'b0, 1'b1, SZ_WORD, 1'b1);
    tick();
    applyStimulus(32'h7C, 32'hCAFE0031, 1'b0, 1'b1, SZ_WORD, 1'b1);
    tick();
    applyStimulus(32'h7C, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1);

    // Dump with ready toggling
    i_dump_start = 1'b1;
    i_dump_ready = 1'b0;
    tick();
    i_dump_start = 1'b0;
    checkOutput("dump_busy", {31'd0, o_dump_busy},  32'd1);
    checkOutput("dump_valid", {31'd0, o_dump_valid}, 32'd1);
    checkOutput("dump_addr0", {27'd0, o_dump_addr}, 32'd0);
    checkOutput("dump_data0", o_dump_data, 32'h0);
    checkOutput("dump_ld", o_read_data, 32'hCAFE0031);
    tick();
    checkOutput("dump_hold0", {27'd0, o_dump_addr}, 32'd0);
    i_dump_ready = 1'b1;
    tick();
    checkOutput("dump_addr1", {27'd0, o_dump_addr}, 32'd1);
    checkOutput("dump_data1", o_dump_data, 32'h00000101);
    i_dump_ready = 1'b0;
    applyStimulus(32'h04, 32'hFFFFFFFF, 1'b0, 1'b1, SZ_WORD, 1'b1);
    tick();
    checkOutput("dump_hold1", {27'd0, o_dump_addr}, 32'd1);
    checkOutput("dump_hold_data", o_dump_data, 32'h00000101);
    applyStimulus(32'h04, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1);
    checkOutput("busy_st_drop", o_read_data, 32'h00000101);
    i_dump_ready = 1'b1;
    for (int n = 0; n < 64 && o_dump_addr != 5'd31; n++) tick();
    checkOutput("dump_addr31", {27'd0, o_dump_addr}, 32'd31);
    checkOutput("dump_data31", o_dump_data, 32'hCAFE0031);
    checkOutput("dump_nodone", {31'd0, o_dump_done}, 32'd0);
    tick();
    checkOutput("dump_done", {31'd0, o_dump_done}, 32'd1);
    checkOutput("done_valid", {31'd0, o_dump_valid}, 32'd0);
    checkOutput("done_busy", {31'd0, o_dump_busy}, 32'd1);
    tick();
    checkOutput("done_pulse", {31'd0, o_dump_done}, 32'd0);
    checkOutput("idle_busy", {31'd0, o_dump_busy}, 32'd0);

    // Reset in the middle of a dump at index 5
    i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    for (int n = 0; n < 20 && o_dump_addr != 5'd5; n++) tick();
    checkOutput("mid_addr5", {27'd0, o_dump_addr}, 32'd5);
    i_reset = 1'b1;
    #1;
    checkOutput("rst_valid", {31'd0, o_dump_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, o_dump_busy}, 32'd0);
    checkOutput("rst_done", {31'd0, o_dump_done}, 32'd0);
    checkOutput("rst_addr", {27'd0, o_dump_addr}, 32'd0);
    checkOutput("rst_data", o_dump_data, 32'h0);
    tick();
    i_reset = 1'b0;
    tick();
    checkOutput("post_rst_done", {31'd0, o_dump_done}, 32'd0);
    applyStimulus(32'h08, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1);
    checkOutput("post_rst_ld", o_read_data, 32'h0);
    applyStimulus(32'h7C, 32'h0, 1'b1, 1'b0, SZ_WORD, 1'b1);
    checkOutput("post_rst_ld31", o_read_data, 32'h0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
